alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU (FORWARD/ADD/AND/OR, SELECT 000–011, 1xx reserved). It accepts an operation from whichever requester wins arbitration and drives the ALU's DATA1/DATA2/SELECT inputs. It holds them stable for an opcode-dependent number of cycles so the ALU's propagation delay settles, then samples the ALU output and returns it to the winner with a one-cycle DONE pulse. The ALU is instantiated beside this block; the arbiter only owns its inputs.

## Interface
- ADD_WAIT, 2 — cycles operands are held before sampling for ADD (001); legal 1–15
- LOGIC_WAIT, 1 — hold cycles for FORWARD/AND/OR (000/010/011); legal 1–15
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- REQ0, REQ1  input  1 each  request; held high, with operands stable, until the matching GNT pulse
- OP0, OP1  input  3 each  ALU opcode of each requester
- A0, A1  input  8 each  operand routed to ALU DATA1
- B0, B1  input  8 each  operand routed to ALU DATA2
- GNT0, GNT1  output  1 each  one-cycle grant pulse; operands captured
- DONE0, DONE1  output  1 each  one-cycle completion pulse; RESULT valid in same cycle
- ERR0, ERR1  output  1 each  pulses with DONE when the opcode was reserved
- RESULT  output  8  shared result register, valid when any DONE is high; holds value otherwise
- BUSY  output  1  high while an operation is in flight (state EXEC)
- ALU_DATA1, ALU_DATA2  output  8 each  to ALU
- ALU_SELECT  output  3  to ALU
- ALU_RESULT  input  8  from ALU

## Operation
- States: IDLE, EXEC. Reset → IDLE.
- IDLE, no REQ: stay; all pulses low.
- IDLE, at least one REQ at edge E0: pick the winner (sole requester, or on tie the requester not granted last). Register GNTx=1. Latch the opcode into an internal register. Update the last-grant pointer. Go to EXEC.
  - Valid opcode (0xx): load ALU_DATA1/ALU_DATA2/ALU_SELECT from the winner's A/B/OP. Counter = wait−1, where wait is ADD_WAIT for 001 and LOGIC_WAIT otherwise.
  - Reserved opcode (1xx): ALU_* outputs unchanged; counter = 0.
- EXEC, counter ≠ 0: decrement; ALU_* held.
- EXEC, counter = 0:
  - Valid opcode: RESULT ← ALU_RESULT.
  - Reserved opcode: RESULT ← 8'h00 and ERRx=1.
  - In both cases DONEx=1 for the granted requester, then → IDLE.
- Round-robin pointer resets to "last granted = 1", so requester 0 wins the first tie. The pointer changes only on a grant.
- Requests are ignored while in EXEC. A REQ still high in IDLE is a new request. Requesters must drop REQ in the cycle GNT is seen if they want only one operation.
- Arithmetic: ADD wraps modulo 256; the arbiter neither checks nor reports carry.
- ALU_* outputs persist after completion until the next valid grant.

## Timing
- Reset values: GNT0/1=0, DONE0/1=0, ERR0/1=0, BUSY=0, RESULT=8'h00, ALU_DATA1=ALU_DATA2=8'h00, ALU_SELECT=3'b000, pointer=1, state IDLE.
- Grant latency: GNT is high in the cycle after edge E0.
- Completion: DONE is high in the cycle after edge E0+W, where W is the wait (reserved opcode: W=1).
- Throughput: the next grant can be sampled at the edge ending the DONE cycle, giving one operation per W+1 cycles. GNT of the next operation never overlaps the DONE of the previous one.
- BUSY is high from the cycle after E0 through the cycle DONE is asserted, then low.
- RESET high at any edge, including mid-EXEC, forces reset values at that edge. The in-flight operation is dropped: no DONE, no ERR. The requester must re-request.
- Simultaneous REQ0/REQ1 in IDLE: exactly one GNT. The loser is served next if it holds REQ.

## Test plan
- Reset then REQ0, OP0=001, A0=8'h05, B0=8'h03, defaults: GNT0 in cycle 1, ALU_SELECT=001, DONE0 in cycle 3 with RESULT=8'h08, BUSY high in cycles 1–3.
- ADD wrap: A0=8'hFF, B0=8'h02, OP 001 → RESULT=8'h01. AND 8'hF0 & 8'h3C → 8'h30 with DONE two cycles after grant edge (LOGIC_WAIT=1).
- Both REQ held continuously with different ops after reset: grants alternate 0,1,0,1. No GNT coincides with DONE. Each DONE matches its own requester's operands.
- Reserved OP1=3'b101, REQ1 only: GNT1, then DONE1 and ERR1 together one cycle later. RESULT=8'h00. ALU_SELECT keeps its prior value.
- RESET asserted during EXEC of an ADD: no DONE/ERR. All outputs at reset values next cycle. Next tie grants requester 0.
- ADD_WAIT=4: a request sampled at E0 yields DONE in the cycle after E0+4. REQ1 asserted during EXEC is granted only after return to IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin sequencer that drives a shared ALU and returns its sampled result
module alu_arbiter #(
  parameter int ADD_WAIT = 2,
  parameter int LOGIC_WAIT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [2:0] OP0,
  input  logic [2:0] OP1,
  input  logic [7:0] A0,
  input  logic [7:0] A1,
  input  logic [7:0] B0,
  input  logic [7:0] B1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic       ERR0,
  output logic       ERR1,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT
);
  typedef enum logic {IDLE, EXEC} state_t;
  localparam logic [3:0] AW = 4'(ADD_WAIT - 1);
  localparam logic [3:0] LW = 4'(LOGIC_WAIT - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic err0_q, err0_d, err1_q, err1_d, busy_q, busy_d;
  logic last_q, last_d, owner_q, owner_d, rsv_q, rsv_d;
  logic [7:0] result_q, result_d, d1_q, d1_d, d2_q, d2_d;
  logic [2:0] sel_q, sel_d, op;
  logic win1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    owner_d = owner_q;
    rsv_d = rsv_q;
    result_d = result_q;
    d1_d = d1_q;
    d2_d = d2_q;
    sel_d = sel_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d = 1'b0;
    err1_d = 1'b0;
    // on a tie, requester 1 wins only if requester 0 was granted last
    win1 = REQ1 & (~REQ0 | ~last_q);
    op = win1 ? OP1 : OP0;
    if (state_q == IDLE && (REQ0 | REQ1)) begin
      state_d = EXEC;
      owner_d = win1;
      last_d = win1;
      gnt0_d = ~win1;
      gnt1_d = win1;
      rsv_d = op[2];
      cnt_d = op[2] ? 4'd0 : (op == 3'b001 ? AW : LW);
      if (!op[2]) begin
        d1_d = win1 ? A1 : A0;
        d2_d = win1 ? B1 : B0;
        sel_d = op;
      end
    end else if (state_q == EXEC) begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = IDLE;
        result_d = rsv_q ? 8'h00 : ALU_RESULT;
        done0_d = ~owner_q;
        done1_d = owner_q;
        err0_d = rsv_q & ~owner_q;
        err1_d = rsv_q & owner_q;
      end
    end
    busy_d = (state_d == EXEC) | done0_d | done1_d;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      rsv_q <= 1'b0;
      result_q <= 8'h00;
      d1_q <= 8'h00;
      d2_q <= 8'h00;
      sel_q <= 3'b000;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      owner_q <= owner_d;
      rsv_q <= rsv_d;
      result_q <= result_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      sel_q <= sel_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
      busy_q <= busy_d;
    end
  end
  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign ERR0 = err0_q;
  assign ERR1 = err1_q;
  assign RESULT = result_q;
  assign BUSY = busy_q;
  assign ALU_DATA1 = d1_q;
  assign ALU_DATA2 = d2_q;
  assign ALU_SELECT = sel_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  logic CLK = 1'b0;
  logic RESET, REQ0, REQ1;
  logic [2:0] OP0, OP1;
  logic [7:0] A0, A1, B0, B1, ALU_RESULT, ALU_RESULT4;
  logic GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY;
  logic [7:0] RESULT, ALU_DATA1, ALU_DATA2;
  logic [2:0] ALU_SELECT;
  logic g0_4, g1_4, dn0_4, dn1_4, e0_4, e1_4, busy_4;
  logic [7:0] res_4, d1_4, d2_4;
  logic [2:0] sel_4;
  int total = 0, bad = 0, last_m;
  logic [7:0] d1_m, d2_m, res_m;
  logic [2:0] sel_m;

  function automatic logic [7:0] alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    return s == 3'd0 ? a : s == 3'd1 ? a + b : s == 3'd2 ? (a & b) : s == 3'd3 ? (a | b) : 8'h00;
  endfunction

  assign ALU_RESULT = alu(ALU_SELECT, ALU_DATA1, ALU_DATA2);
  assign ALU_RESULT4 = alu(sel_4, d1_4, d2_4);

  alu_arbiter #(.ADD_WAIT(2), .LOGIC_WAIT(1)) dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1), .GNT0(GNT0), .GNT1(GNT1),
    .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1), .RESULT(RESULT), .BUSY(BUSY),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT));

  alu_arbiter #(.ADD_WAIT(4), .LOGIC_WAIT(1)) dut4 (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1), .GNT0(g0_4), .GNT1(g1_4),
    .DONE0(dn0_4), .DONE1(dn1_4), .ERR0(e0_4), .ERR1(e1_4), .RESULT(res_4), .BUSY(busy_4),
    .ALU_DATA1(d1_4), .ALU_DATA2(d2_4), .ALU_SELECT(sel_4), .ALU_RESULT(ALU_RESULT4));

  always #5 CLK = ~CLK;

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    cyc;
    last_m = 1;
    sel_m = 3'b000;
    d1_m = 8'h00;
    d2_m = 8'h00;
    res_m = 8'h00;
    chk("rst_pulses", {GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY}, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_alu", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, 0);
    RESET = 1'b0;
  endtask

  task automatic idle_chk;
    cyc;
    chk("idle_pulses", {GNT0, GNT1, DONE0, DONE1, ERR0, ERR1, BUSY}, 0);
    chk("idle_result", RESULT, res_m);
  endtask

  // one transaction on the ADD_WAIT=2 instance; returns after checking the DONE cycle
  task automatic txn(input bit q0, input bit q1, input bit hold, input logic [2:0] o0, input logic [2:0] o1,
                     input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1, input logic [7:0] b1);
    int w, wt;
    logic [2:0] o;
    logic [7:0] a, b;
    REQ0 = q0; REQ1 = q1; OP0 = o0; OP1 = o1; A0 = a0; B0 = b0; A1 = a1; B1 = b1;
    w = (q0 && q1) ? (last_m == 1 ? 0 : 1) : (q1 ? 1 : 0);
    o = w ? o1 : o0;
    a = w ? a1 : a0;
    b = w ? b1 : b0;
    last_m = w;
    if (!o[2]) begin
      sel_m = o; d1_m = a; d2_m = b;
    end
    wt = o[2] ? 1 : (o == 3'b001 ? 2 : 1);
    cyc;
    chk("gnt0", GNT0, w == 0);
    chk("gnt1", GNT1, w == 1);
    chk("busy_gnt", BUSY, 1);
    chk("done_at_gnt", {DONE0, DONE1}, 0);
    chk("alu_inputs", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, {d1_m, d2_m, sel_m});
    if (!hold) begin
      REQ0 = 1'b0; REQ1 = 1'b0;
    end
    for (int k = 1; k <= wt; k++) begin
      cyc;
      if (k < wt) chk("done_early", {DONE0, DONE1, GNT0, GNT1}, 0);
    end
    res_m = o[2] ? 8'h00 : alu(o, a, b);
    chk("done0", DONE0, w == 0);
    chk("done1", DONE1, w == 1);
    chk("err0", ERR0, w == 0 && o[2]);
    chk("err1", ERR1, w == 1 && o[2]);
    chk("result", RESULT, res_m);
    chk("gnt_at_done", {GNT0, GNT1}, 0);
    chk("busy_done", BUSY, 1);
    chk("alu_hold", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, {d1_m, d2_m, sel_m});
  endtask

  initial begin
    RESET = 1'b1; REQ0 = 0; REQ1 = 0; OP0 = 0; OP1 = 0; A0 = 0; A1 = 0; B0 = 0; B1 = 0;
    cyc;
    do_reset;
    txn(1, 0, 0, 3'b001, 3'b000, 8'h05, 8'h03, 8'h00, 8'h00);
    idle_chk;
    txn(1, 0, 0, 3'b001, 3'b000, 8'hFF, 8'h02, 8'h00, 8'h00);
    txn(1, 0, 0, 3'b010, 3'b000, 8'hF0, 8'h3C, 8'h00, 8'h00);
    idle_chk;
    do_reset;
    for (int n = 0; n < 4; n++) txn(1, 1, n < 3, 3'b001, 3'b011, 8'h11, 8'h22, 8'h0F, 8'hA0);
    idle_chk;
    txn(0, 1, 0, 3'b000, 3'b101, 8'h00, 8'h00, 8'hAA, 8'h55);
    idle_chk;
    REQ0 = 1'b1; OP0 = 3'b001; A0 = 8'h10; B0 = 8'h20;
    cyc;
    chk("mid_gnt0", GNT0, 1);
    REQ0 = 1'b0;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk("dropped_op", {DONE0, DONE1, ERR0, ERR1, BUSY}, 0);
    end
    txn(1, 1, 0, 3'b000, 3'b010, 8'h77, 8'h00, 8'h33, 8'h0F);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] p;
      p = 2'($urandom_range(1, 3));
      txn(p[0], p[1], 0, 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle_chk;
    end
    do_reset;
    REQ0 = 1'b1; OP0 = 3'b001; A0 = 8'hC8; B0 = 8'h64;
    cyc;
    chk("w4_gnt0", {g0_4, g1_4, busy_4}, 3'b101);
    REQ0 = 1'b0;
    REQ1 = 1'b1; OP1 = 3'b010; A1 = 8'hFF; B1 = 8'h0F;
    for (int k = 1; k <= 4; k++) begin
      cyc;
      if (k < 4) chk("w4_wait", {dn0_4, g1_4}, 0);
    end
    chk("w4_done0", {dn0_4, e0_4, busy_4, g1_4}, 4'b1010);
    chk("w4_result", res_4, 8'h2C);
    cyc;
    chk("w4_gnt1", {g1_4, dn0_4}, 2'b10);
    REQ1 = 1'b0;
    cyc;
    chk("w4_done1", {dn1_4, e1_4}, 2'b10);
    chk("w4_result1", res_4, 8'h0F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
